// File: rtl/asrm_irq_conditioner_pkg.sv
// Shared constants for the external interrupt conditioner: line count and
// per-line trigger mode encodings.
package asrm_irq_conditioner_pkg;

  localparam int NUM_INT = 4;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  typedef logic [NUM_INT-1:0] irq_vec_t;

endpackage

// File: rtl/asrm_irq_filter.sv
// One interrupt line: two-flop synchronizer followed by a debounce filter.
// rise is high in the cycle whose closing edge moves filtered from 0 to 1.
module asrm_irq_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic filtered,
  output logic rise
);

  localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] count;
  logic          expire;

  // Mismatch has persisted long enough: filtered takes s2 on this edge.
  assign expire = (s2 != filtered) && (count == CNT_MAX);
  assign rise   = expire && s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      filtered <= 1'b0;
      count    <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      if (s2 == filtered) begin
        count <= '0;
      end else if (expire) begin
        filtered <= s2;
        count    <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/asrm_irq_conditioner.sv
// Conditions four asynchronous interrupt lines into latched, maskable requests
// for the CPU interrupt handler.
module asrm_irq_conditioner
  import asrm_irq_conditioner_pkg::*;
#(
  parameter int       DEBOUNCE_CYCLES = 4,
  parameter irq_vec_t EDGE_MODE       = 4'b1111
) (
  input  logic     clk,
  input  logic     reset,
  input  irq_vec_t irq_in,
  input  irq_vec_t mask,
  input  irq_vec_t irq_ack,
  output irq_vec_t pending,
  output irq_vec_t ext_int
);

  irq_vec_t filtered;
  irq_vec_t rise;
  irq_vec_t pending_next;

  generate
    for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_line
      asrm_irq_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq_in[gi]),
        .filtered(filtered[gi]),
        .rise    (rise[gi])
      );
    end
  endgenerate

  // A fresh rise beats an ack so no event is lost; a standing level yields to
  // the ack for one edge and re-asserts on the next while the line stays high.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NUM_INT; i++) begin
      if (rise[i]) begin
        pending_next[i] = 1'b1;
      end else if (irq_ack[i]) begin
        pending_next[i] = 1'b0;
      end else if ((EDGE_MODE[i] == MODE_LEVEL) && filtered[i]) begin
        pending_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign ext_int = pending & mask;

endmodule

// File: doc/asrm_irq_conditioner.md
ASRM_IRQ_CONDITIONER -- requirements
Module: asrm_irq_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable synchronized samples needed before a line's filtered level changes; 0 = no debounce.
REQ-002 Parameter EDGE_MODE, default 4'b1111, SHALL select per line: 1 = rising-edge triggered, 0 = level triggered.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 irq_in  input  4  raw external interrupt requests, asynchronous to clk; irq_in[0] is interrupt 0.
REQ-006 mask  input  4  per-line enable; 1 = line delivered downstream.
REQ-007 irq_ack  input  4  per-line clear from the interrupt handler, one-cycle pulse.
REQ-008 pending  output  4  latched request per line, regardless of mask.
REQ-009 ext_int  output  4  pending & mask; drives the ext_int[3:0] input of the CPU interrupt handler.

Function
REQ-010 Each irq_in bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-011 Per line, filtered SHALL track s2 through a debounce counter: counter cleared when s2 == filtered; incremented when s2 != filtered; when counter == max(DEBOUNCE_CYCLES,1)-1 and s2 != filtered, filtered <= s2 and counter <= 0 on that edge.
REQ-012 A synchronized pulse shorter than max(DEBOUNCE_CYCLES,1) cycles SHALL leave filtered unchanged and clear the counter.
REQ-013 Counter width SHALL be the minimum to hold DEBOUNCE_CYCLES-1; no wrap-around possible.
REQ-014 Edge mode: pending[i] SHALL set on the edge where filtered[i] updates 0->1; falling transitions never set pending.
REQ-015 Level mode: pending[i] SHALL set on every edge where filtered[i] is 1.
REQ-016 irq_ack[i] SHALL clear pending[i] on the next edge.
REQ-017 Set and irq_ack on the same edge: set SHALL win, pending stays 1 (no event lost).
REQ-018 irq_ack on a line not pending SHALL have no effect.
REQ-019 Masked lines SHALL still latch pending; unmasking a pending line SHALL raise ext_int combinationally the same cycle.
REQ-020 ext_int SHALL be combinational from pending and mask only; no path from irq_in to ext_int without passing the synchronizer.
REQ-021 Latency: irq_in rising before edge 1 and held SHALL give pending/ext_int high after edge 2+max(DEBOUNCE_CYCLES,1) (edge 6 at default).
REQ-022 Multiple lines SHALL be handled independently; no priority inside this block.

Reset
REQ-023 reset SHALL asynchronously clear s1, s2, filtered, all counters and pending; pending and ext_int SHALL be 0 while reset is high.
REQ-024 Reset mid-debounce or with pending set SHALL discard the event; after release, a still-high irq_in SHALL be treated as a new 0->1 transition.

Structure
REQ-025 Shared package SHALL hold NUM_INT = 4 and the edge/level mode encodings.
REQ-026 One sub-module asrm_irq_filter (synchronizer + debounce for one line, output filtered and rise strobe) SHALL be instantiated NUM_INT times; pending/mask/ack logic stays in the top.

Verification
REQ-027 Default params, mask=4'b0001, irq_in[0] 0->1 held -> pending[0]=1 and ext_int=4'b0001 after edge 6, not before; irq_ack[0] pulse -> ext_int=0 next edge, stays 0 while irq_in held (edge mode).
REQ-028 irq_in[1] high for 2 synchronized cycles then low (DEBOUNCE_CYCLES=4) -> pending stays 4'b0000.
REQ-029 EDGE_MODE=4'b1101, irq_in[1] held high, ack pulse on line 1 -> pending[1] re-sets on the following edge; ext_int[1] returns to 1.
REQ-030 Edge-mode rise on line 2 coincident with irq_ack[2] while pending[2]=1 -> pending[2] remains 1.
REQ-031 mask=0, irq_in[3] event -> pending=4'b1000, ext_int=0; mask[3] set -> ext_int=4'b1000 same cycle.
REQ-032 reset asserted asynchronously with pending=4'b1111 mid-cycle -> pending=0 immediately; after release with irq_in[0] held high -> pending[0] sets after edge 6 from release.
